ifu: RTL

Instruction fetch unit for the RV32E NPC core. Holds the program counter, issues one word-aligned fetch per instruction to the instruction memory over a valid/ready request plus valid response channel, and buffers the returned word for the decode stage. It sits directly upstream of the decoder and presents `inst`/`inst_pc` with a valid/ready handshake. It accepts PC redirects from execute for jumps and branches and discards any fetch rendered stale by a redirect.

---
 rtl/ifu.sv | 115 +++++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit for the RV32E NPC core.
// Holds the PC, issues one word-aligned fetch at a time to instruction memory,
// buffers the returned word for decode and discards fetches made stale by a
// redirect from execute.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          ILEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [ILEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [ILEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [ILEN-1:0] inst_pc,
  input  logic            inst_ready
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD
  } state_t;

  localparam logic [ILEN-1:0] NOP      = ILEN'(32'h0000_0013);
  localparam logic [ILEN-1:0] START_PC = ILEN'(RESET_PC);

  state_t          state;
  logic [ILEN-1:0] pc;
  logic            drop;
  logic [ILEN-1:0] target;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign target = redirect_pc & ~(ILEN'(3));

  // Outputs come straight from registers or from the state encoding only.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == HOLD);

  // Fetch sequencer: a redirect wins over every other event in its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= START_PC;
      drop    <= 1'b0;
      inst    <= NOP;
      inst_pc <= START_PC;
    end else begin
      case (state)
        BOOT: begin
          if (redirect_valid) begin
            pc <= target;
          end
          state <= REQ;
        end

        REQ: begin
          if (redirect_valid) begin
            pc <= target;
            if (imem_req_ready) begin
              // The old address already left; its response must be thrown away.
              drop  <= 1'b1;
              state <= WAIT;
            end
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc <= target;
            if (imem_rsp_valid) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
              state   <= HOLD;
            end
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc    <= target;
            state <= REQ;
          end else if (inst_ready) begin
            pc    <= pc + ILEN'(4);
            state <= REQ;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
